// File: rtl/udp_rx_parser.sv
// udp_rx_parser: pops raw UDP datagram bytes from a byte FIFO with one-cycle
// read latency, captures the 8-byte header, streams the payload downstream and
// reports the length and ones'-complement checksum status once per packet.
module udp_rx_parser #(
    parameter int MAX_LEN = 2048
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  fifo_dout,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    output logic [15:0] src_port,
    output logic [15:0] dst_port,
    output logic [15:0] udp_len,
    output logic [15:0] udp_cksum,
    output logic        hdr_valid,
    output logic [7:0]  pl_data,
    output logic        pl_valid,
    output logic        pl_last,
    output logic        pkt_done,
    output logic        cksum_ok,
    output logic        len_err
);

    localparam logic [1:0]  ST_HDR     = 2'd0;
    localparam logic [1:0]  ST_PAYLOAD = 2'd1;
    localparam logic [1:0]  ST_DONE    = 2'd2;
    localparam logic [16:0] MAX_LEN_W  = 17'(MAX_LEN);

    logic [1:0]  state_q, state_d;
    logic [15:0] req_cnt_q, req_cnt_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic        rd_pend_q, rd_pend_d;
    logic [15:0] src_q, src_d;
    logic [15:0] dst_q, dst_d;
    logic [15:0] len_q, len_d;
    logic [15:0] ck_q, ck_d;
    logic [15:0] acc_q, acc_d;
    logic        hdr_valid_q, hdr_valid_d;
    logic [7:0]  pl_data_q, pl_data_d;
    logic        pl_valid_q, pl_valid_d;
    logic        pl_last_q, pl_last_d;
    logic        len_err_q, len_err_d;

    logic        rd_en;
    logic        len_bad;
    logic [15:0] add_word;
    logic [16:0] sum_raw;
    logic [15:0] acc_next;

    // The length field is complete once header byte 5 has been captured,
    // so it can be judged while byte 7 is being captured.
    assign len_bad = (len_q < 16'd8) || ({1'b0, len_q} > MAX_LEN_W);

    // Pop request: only while out of reset, the FIFO has data and the current
    // packet still owes bytes, so a pop never reaches into the next packet.
    always_comb begin
        rd_en = 1'b0;
        if (rst_n && !fifo_empty) begin
            if (state_q == ST_HDR && req_cnt_q < 16'd8) begin
                rd_en = 1'b1;
            end else if (state_q == ST_PAYLOAD && req_cnt_q < len_q) begin
                rd_en = 1'b1;
            end
        end
    end

    // Ones'-complement add of the byte being captured, placed in the high half
    // for even positions and the low half for odd ones; a trailing odd byte is
    // thereby padded with zero automatically.
    always_comb begin
        add_word = rx_cnt_q[0] ? {8'h00, fifo_dout} : {fifo_dout, 8'h00};
        sum_raw  = {1'b0, acc_q} + {1'b0, add_word};
        acc_next = sum_raw[15:0] + {15'd0, sum_raw[16]};
    end

    // Next-state logic: byte capture, header decode, payload streaming and the
    // single DONE cycle that reports status and clears per-packet state.
    always_comb begin
        state_d     = state_q;
        req_cnt_d   = req_cnt_q + {15'd0, rd_en};
        rx_cnt_d    = rx_cnt_q;
        rd_pend_d   = rd_en;
        src_d       = src_q;
        dst_d       = dst_q;
        len_d       = len_q;
        ck_d        = ck_q;
        acc_d       = acc_q;
        hdr_valid_d = 1'b0;
        pl_data_d   = pl_data_q;
        pl_valid_d  = 1'b0;
        pl_last_d   = 1'b0;
        len_err_d   = len_err_q;

        if (rd_pend_q) begin
            acc_d    = acc_next;
            rx_cnt_d = rx_cnt_q + 16'd1;
        end

        case (state_q)
            ST_HDR: begin
                if (hdr_valid_q) begin
                    state_d = ST_DONE;
                end else if (rd_pend_q) begin
                    case (rx_cnt_q[2:0])
                        3'd0: src_d[15:8] = fifo_dout;
                        3'd1: src_d[7:0]  = fifo_dout;
                        3'd2: dst_d[15:8] = fifo_dout;
                        3'd3: dst_d[7:0]  = fifo_dout;
                        3'd4: len_d[15:8] = fifo_dout;
                        3'd5: len_d[7:0]  = fifo_dout;
                        3'd6: ck_d[15:8]  = fifo_dout;
                        default: ck_d[7:0] = fifo_dout;
                    endcase
                    if (rx_cnt_q[2:0] == 3'd7) begin
                        hdr_valid_d = 1'b1;
                        len_err_d   = len_bad;
                        if (!len_bad && len_q != 16'd8) begin
                            state_d = ST_PAYLOAD;
                        end
                    end
                end
            end
            ST_PAYLOAD: begin
                if (rd_pend_q) begin
                    pl_data_d  = fifo_dout;
                    pl_valid_d = 1'b1;
                    pl_last_d  = (rx_cnt_q == len_q - 16'd1);
                end
                if (pl_valid_q && pl_last_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d   = ST_HDR;
                req_cnt_d = 16'd0;
                rx_cnt_d  = 16'd0;
                acc_d     = 16'd0;
                len_err_d = 1'b0;
            end
            default: begin
                state_d = ST_HDR;
            end
        endcase
    end

    // State registers; reset abandons any packet in flight and clears outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_HDR;
            req_cnt_q   <= 16'd0;
            rx_cnt_q    <= 16'd0;
            rd_pend_q   <= 1'b0;
            src_q       <= 16'd0;
            dst_q       <= 16'd0;
            len_q       <= 16'd0;
            ck_q        <= 16'd0;
            acc_q       <= 16'd0;
            hdr_valid_q <= 1'b0;
            pl_data_q   <= 8'd0;
            pl_valid_q  <= 1'b0;
            pl_last_q   <= 1'b0;
            len_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_cnt_q   <= req_cnt_d;
            rx_cnt_q    <= rx_cnt_d;
            rd_pend_q   <= rd_pend_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            len_q       <= len_d;
            ck_q        <= ck_d;
            acc_q       <= acc_d;
            hdr_valid_q <= hdr_valid_d;
            pl_data_q   <= pl_data_d;
            pl_valid_q  <= pl_valid_d;
            pl_last_q   <= pl_last_d;
            len_err_q   <= len_err_d;
        end
    end

    assign fifo_rd_en = rd_en;
    assign src_port   = src_q;
    assign dst_port   = dst_q;
    assign udp_len    = len_q;
    assign udp_cksum  = ck_q;
    assign hdr_valid  = hdr_valid_q;
    assign pl_data    = pl_data_q;
    assign pl_valid   = pl_valid_q;
    assign pl_last    = pl_last_q;
    assign pkt_done   = (state_q == ST_DONE);
    assign len_err    = (state_q == ST_DONE) && len_err_q;
    assign cksum_ok   = (state_q == ST_DONE) && !len_err_q &&
                        ((ck_q == 16'd0) || (acc_q == 16'hFFFF));

endmodule
